// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned FQ_ADDR_W   = 16;
    localparam int unsigned FQ_INSTR_W  = 16;
    localparam int unsigned FQ_DEPTH    = 4;
    localparam int unsigned FQ_RESET_PC = 0;
    localparam int unsigned FQ_PC_INC   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    // Default-width view of one buffered fetch; the top re-declares it at its own widths.
    typedef struct packed {
        logic [FQ_INSTR_W-1:0] instr;
        logic [FQ_ADDR_W-1:0]  pc;
        logic [FQ_ADDR_W-1:0]  pc_next;
    } fetch_entry_t;

    function automatic int unsigned entry_width(input int unsigned addr_w,
                                                input int unsigned instr_w);
        return instr_w + 2 * addr_w;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with push, pop, flush and occupancy count.
module fetch_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 48,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & ~flush & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC owner, single-outstanding imem reader, prefetch FIFO.
// Optional combinational response bypass when the FIFO is empty: define FETCH_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = FQ_ADDR_W,
    parameter int unsigned        INSTR_W  = FQ_INSTR_W,
    parameter int unsigned        DEPTH    = FQ_DEPTH,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(FQ_RESET_PC),
    parameter int unsigned        PC_INC   = FQ_PC_INC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_done,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_next,
    output logic               busy,
    output logic               err
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = entry_width(ADDR_W, INSTR_W);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_next;
    } entry_t;

    fetch_state_t      state, state_d;
    logic [ADDR_W-1:0] pc, pc_d, pc_inc;
    logic [ADDR_W-1:0] addr_q;
    entry_t            push_entry, head;
    logic [CNT_W-1:0]  fifo_count, cnt_after;
    logic              fifo_empty;
    logic              resp_ok;
    logic              push, pop;
    logic              can_issue;

    assign pc_inc  = pc + ADDR_W'(PC_INC);
    assign resp_ok = (state == REQ) & imem_done & ~redirect;
    assign pop     = out_ready & ~fifo_empty & ~redirect;

    assign push_entry = '{instr: imem_data, pc: pc, pc_next: pc_inc};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

`ifdef FETCH_BYPASS_EN
    logic byp_hit;

    assign byp_hit = fifo_empty & resp_ok;
    assign push    = resp_ok & ~(byp_hit & out_ready);

    always_comb begin
        out_valid   = ~fifo_empty | byp_hit;
        out_instr   = head.instr;
        out_pc      = head.pc;
        out_pc_next = head.pc_next;
        if (byp_hit) begin
            out_instr   = imem_data;
            out_pc      = pc;
            out_pc_next = pc_inc;
        end
    end
`else
    assign push = resp_ok;

    always_comb begin
        out_valid   = ~fifo_empty;
        out_instr   = head.instr;
        out_pc      = head.pc;
        out_pc_next = head.pc_next;
    end
`endif

    // Occupancy after this edge decides issue, so at most one response can land per free slot.
    always_comb begin
        if (redirect)
            cnt_after = '0;
        else
            cnt_after = fifo_count + CNT_W'(push) - CNT_W'(pop);
        can_issue = ~halt & (cnt_after < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                state_d = can_issue ? REQ : IDLE;
            end
            REQ: begin
                if (imem_done)
                    state_d = can_issue ? REQ : IDLE;
                else if (redirect)
                    state_d = SQUASH;
                else
                    state_d = REQ;
            end
            // A redirect landing with the squashed response may issue straight to the new target.
            SQUASH: begin
                if (imem_done)
                    state_d = can_issue ? REQ : IDLE;
                else
                    state_d = SQUASH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_rd = (state != IDLE);
        busy    = (state != IDLE);
    end

    always_comb begin
        pc_d = pc;
        if (redirect)
            pc_d = redirect_pc;
        else if ((state == REQ) && imem_done)
            pc_d = pc_inc;
    end

    // The request address is frozen during SQUASH so the abandoned read stays stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            err    <= 1'b0;
        end else begin
            pc <= pc_d;
            if (state_d != SQUASH)
                addr_q <= pc_d;
            if ((state == REQ) && imem_done && imem_err)
                err <= 1'b1;
        end
    end

    assign imem_addr = addr_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: streaming, backpressure, squash, errors, halt, PC wrap.
module tb_fetch_queue;

`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        halt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_done;
    logic [15:0] imem_data;
    logic        imem_err;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_pc_next;
    logic        busy;
    logic        err;

    logic        auto_done;
    logic        man_done;

    logic        w_rst;
    logic        w_imem_rd;
    logic [15:0] w_imem_addr;
    logic        w_imem_done;
    logic        w_out_valid;
    logic [15:0] w_out_instr;
    logic [15:0] w_out_pc;
    logic [15:0] w_out_pc_next;
    logic        w_busy;
    logic        w_err;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] dat(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    assign imem_done   = imem_rd & (auto_done | man_done);
    assign imem_data   = dat(imem_addr);
    assign w_imem_done = w_imem_rd;

    fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_done   (imem_done),
        .imem_data   (imem_data),
        .imem_err    (imem_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc_next (out_pc_next),
        .busy        (busy),
        .err         (err)
    );

    fetch_queue #(
        .RESET_PC (16'hFFFE)
    ) dut_wrap (
        .clk         (clk),
        .rst         (w_rst),
        .halt        (1'b0),
        .redirect    (1'b0),
        .redirect_pc (16'h0000),
        .imem_rd     (w_imem_rd),
        .imem_addr   (w_imem_addr),
        .imem_done   (w_imem_done),
        .imem_data   (16'h1234),
        .imem_err    (1'b0),
        .out_valid   (w_out_valid),
        .out_ready   (1'b0),
        .out_instr   (w_out_instr),
        .out_pc      (w_out_pc),
        .out_pc_next (w_out_pc_next),
        .busy        (w_busy),
        .err         (w_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b0;
        w_rst       = 1'b0;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_err    = 1'b0;
        out_ready   = 1'b0;
        auto_done   = 1'b0;
        man_done    = 1'b0;

        // Reset state
        step(); step();
        chk("rst_imem_rd",   imem_rd,   0);
        chk("rst_imem_addr", imem_addr, 16'h0000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_err",       err,       0);
        chk("w_rst_addr",    w_imem_addr, 16'hFFFE);
        chk("w_rst_busy",    w_busy,    0);

        // Streaming with 1-cycle memory and decode always ready
        rst = 1'b1; auto_done = 1'b1; out_ready = 1'b1;
        step();
        chk("t1_rd",     imem_rd,   1);
        chk("t1_addr0",  imem_addr, 16'h0000);
        chk("t1_valid0", out_valid, BYP);
        step();
        chk("t1_addr2",    imem_addr,   16'h0002);
        chk("t1_valid",    out_valid,   1);
        chk("t1_pc0",      out_pc,      BYP ? 16'h0002 : 16'h0000);
        chk("t1_pcnext0",  out_pc_next, BYP ? 16'h0004 : 16'h0002);
        chk("t1_instr0",   out_instr,   dat(BYP ? 16'h0002 : 16'h0000));
        chk("t1_err0",     err,         0);
        step();
        chk("t1_addr4", imem_addr, 16'h0004);
        chk("t1_pc2",   out_pc,    BYP ? 16'h0004 : 16'h0002);
        imem_err = 1'b1;
        step();
        imem_err = 1'b0;
        chk("t1_err_set", err,       1);
        chk("t1_addr6",   imem_addr, 16'h0006);
        chk("t1_pc4",     out_pc,    BYP ? 16'h0006 : 16'h0004);
        step(); step();
        chk("t1_err_sticky", err,       1);
        chk("t1_addr10",     imem_addr, 16'h000A);
        chk("t1_busy",       busy,      1);

        // Asynchronous reset in the middle of a read
        rst = 1'b0; out_ready = 1'b0;
        #1;
        chk("arst_rd",    imem_rd,   0);
        chk("arst_busy",  busy,      0);
        chk("arst_valid", out_valid, 0);
        chk("arst_err",   err,       0);
        chk("arst_addr",  imem_addr, 16'h0000);
        step();
        rst = 1'b1;

        // Backpressure: FIFO fills with four entries then fetch stops
        step(); step(); step(); step();
        chk("t2_rd_3push", imem_rd,   1);
        chk("t2_addr6",    imem_addr, 16'h0006);
        step();
        chk("t2_idle_rd",   imem_rd,   0);
        chk("t2_idle_busy", busy,      0);
        chk("t2_idle_addr", imem_addr, 16'h0008);
        chk("t2_valid",     out_valid, 1);
        chk("t2_head_pc",   out_pc,    16'h0000);
        step();
        chk("t2_still_idle", imem_rd, 0);
        chk("t2_head_hold",  out_pc,  16'h0000);
        out_ready = 1'b1;
        step();
        chk("t2_resume_rd",   imem_rd,   1);
        chk("t2_resume_addr", imem_addr, 16'h0008);
        chk("t2_resume_pc",   out_pc,    16'h0002);
        step();
        chk("t2_addr10", imem_addr, 16'h000A);
        chk("t2_pc4",    out_pc,    16'h0004);

        // Redirect while the read of 0x0006 is pending
        rst = 1'b0;
        step();
        rst = 1'b1;
        step(); step(); step(); step();
        auto_done = 1'b0;
        step();
        chk("t3_pend_rd",    imem_rd,   1);
        chk("t3_pend_addr",  imem_addr, 16'h0006);
        chk("t3_pend_valid", out_valid, 0);
        redirect = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        chk("t3_sq_rd",    imem_rd,   1);
        chk("t3_sq_addr",  imem_addr, 16'h0006);
        chk("t3_sq_busy",  busy,      1);
        chk("t3_sq_valid", out_valid, 0);
        step();
        chk("t3_sq_addr2",  imem_addr, 16'h0006);
        chk("t3_sq_valid2", out_valid, 0);
        man_done = 1'b1; imem_err = 1'b1;
        step();
        man_done = 1'b0; imem_err = 1'b0;
        chk("t3_new_rd",    imem_rd,   1);
        chk("t3_new_addr",  imem_addr, 16'h0100);
        chk("t3_new_valid", out_valid, 0);
        chk("t3_sq_err",    err,       0);
        auto_done = 1'b1;
        step();
        chk("t3_ret_valid", out_valid, 1);
        chk("t3_ret_pc",    out_pc,    BYP ? 16'h0102 : 16'h0100);
        chk("t3_ret_instr", out_instr, dat(BYP ? 16'h0102 : 16'h0100));

        // Halt mid-read: the read completes and nothing further is issued
        halt = 1'b1;
        step();
        chk("t5_halt_rd",    imem_rd,   0);
        chk("t5_halt_busy",  busy,      0);
        chk("t5_halt_valid", out_valid, !BYP);
`ifndef FETCH_BYPASS_EN
        chk("t5_halt_pc", out_pc, 16'h0102);
`endif
        step();
        chk("t5_drain_valid", out_valid, 0);
        chk("t5_drain_rd",    imem_rd,   0);
        halt = 1'b0;
        step();
        chk("t5_unhalt_rd",   imem_rd,   1);
        chk("t5_unhalt_addr", imem_addr, 16'h0104);

        // PC wrap from RESET_PC = 0xFFFE
        w_rst = 1'b1;
        step();
        chk("w_rd",   w_imem_rd,   1);
        chk("w_addr", w_imem_addr, 16'hFFFE);
        step();
        chk("w_valid",   w_out_valid,   1);
        chk("w_pc",      w_out_pc,      16'hFFFE);
        chk("w_pc_next", w_out_pc_next, 16'h0000);
        chk("w_instr",   w_out_instr,   16'h1234);
        chk("w_addr0",   w_imem_addr,   16'h0000);
        chk("w_err",     w_err,         0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end with decoupled prefetch buffer. Owns the PC and issues one outstanding read at a time to the instruction memory/cache over a hold-until-done handshake. Buffers returned instructions in a DEPTH-entry FIFO that decode drains with valid/ready. Redirects flush the buffer and squash in-flight reads. Sits between the PC-redirect logic (branch/jump resolution) and the decode stage.

## Interface
- ADDR_W, 16, PC / memory address width
- INSTR_W, 16, instruction width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 0, PC value after reset
- PC_INC, 2, PC increment per instruction (half-word aligned)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- halt  in  1  when high, no new memory read is issued
- redirect  in  1  branch/jump taken; flush and restart at redirect_pc
- redirect_pc  in  ADDR_W  redirect target
- imem_rd  out  1  read request, held high until imem_done
- imem_addr  out  ADDR_W  read address, stable while imem_rd high
- imem_done  in  1  read complete; imem_data/imem_err valid this cycle
- imem_data  in  INSTR_W  returned instruction
- imem_err  in  1  memory error for this read
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts; pop when out_valid & out_ready
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  PC of head instruction
- out_pc_next  out  ADDR_W  out_pc + PC_INC (mod 2^ADDR_W)
- busy  out  1  read outstanding (state REQ or SQUASH)
- err  out  1  sticky memory error

## Operation
- States: IDLE (imem_rd=0), REQ (imem_rd=1, addr=pc), SQUASH (imem_rd=1, response discarded).
- can_issue = ~halt & (count_after_this_cycle < DEPTH).
- IDLE: can_issue → REQ.
- REQ, imem_done, no redirect: push {imem_data, pc, pc+PC_INC}; pc ← pc+PC_INC; → REQ if can_issue else IDLE.
- REQ, ~imem_done: hold.
- Redirect (any state, highest priority): FIFO flushed (count←0), pc←redirect_pc, concurrent pop and push ignored. From IDLE, or REQ with imem_done: → REQ if ~halt else IDLE. From REQ without imem_done: → SQUASH. From SQUASH: stay SQUASH.
- SQUASH, imem_done: discard; → REQ if ~halt & no new redirect-induced conflict, else IDLE.
- err set on imem_done & imem_err in REQ only (not squashed); cleared only by reset.
- PC and out_pc_next wrap modulo 2^ADDR_W.
- Simultaneous push and pop with FIFO full: pop frees slot; push accepted; count unchanged.
- halt mid-read: read completes and is pushed; no further issue.

## Timing
- Reset values: pc=RESET_PC, state IDLE, count=0, imem_rd=0, imem_addr=RESET_PC, out_valid=0, busy=0, err=0.
- First imem_rd high in the second cycle after rst deasserts (IDLE→REQ).
- Back-to-back: with done every cycle and decode always ready, one instruction per cycle sustained.
- Pushed entry visible on out_valid the cycle after imem_done (no bypass).
- Redirect at edge t: out_valid=0 and imem_rd=1, imem_addr=redirect_pc after t (unless SQUASH needed).
- Reset mid-read: imem_rd drops immediately (asynchronous); memory must tolerate abandoned read.

## Configuration
- FETCH_BYPASS_EN defined: when FIFO empty and REQ receives imem_done without redirect, out_valid/out_instr/out_pc driven combinationally from the response the same cycle; if out_ready, entry is not pushed. out_valid then has a combinational path from imem_done.
- Undefined: all responses pass through the FIFO; outputs are purely registered/FIFO-head driven.

## Structure
- Package fetch_pkg: state enum (IDLE, REQ, SQUASH), fetch entry struct {instr, pc, pc_next}, default parameter constants.
- Sub-module fetch_fifo: synchronous FIFO with push, pop, flush, count; parametrised by DEPTH and entry width.

## Test plan
- Reset release, memory done 1 cycle latency, out_ready=1 -> imem_addr 0,2,4,...; out_pc 0,2,4 one per cycle; err=0.
- out_ready=0, DEPTH=4 -> exactly 4 pushes, then state IDLE, imem_rd=0; raise out_ready -> fetch resumes at pc=8.
- Redirect to 0x0100 while read of 0x0006 pending (done 3 cycles later) -> SQUASH; 0x0006 data never on out; next imem_addr 0x0100; out_valid=0 until 0x0100 returns.
- imem_err=1 on read of 0x0004 -> err=1 and stays 1; imem_err on squashed read -> err stays 0.
- RESET_PC=0xFFFE -> out_pc 0xFFFE, out_pc_next 0x0000, next imem_addr 0x0000.
- FETCH_BYPASS_EN, FIFO empty, done with out_ready=1 -> out_valid same cycle, count stays 0.
